ram_dp_be: RTL
==============

// Module: ram_dp_be
// PURPOSE
//  Simple dual-port RAM: one write port, one read port, one clock. Per-byte write enables.
//  Selectable read latency (0 = asynchronous, 1 = registered). Defined read-during-write mode.
//  Post-reset init sweep writes INIT_VALUE to every word before the RAM accepts traffic.
//  Drop-in successor to the single-port RAM for data memories and register-file-backed buffers.
// PARAMETERS
//  WIDTH        32        data word width in bits; must be a multiple of 8
//  DEPTH        1024      number of words; need not be a power of 2
//  READ_LATENCY 1         0 = combinational read, 1 = registered read
//  RDW_MODE     RDW_NEW   same-address read/write in the same cycle (latency 1 only): RDW_NEW | RDW_OLD
//  INIT_VALUE   '0        value written to every word by the init sweep
//  Derived:     AW = $clog2(DEPTH), NB = WIDTH/8
// PORTS
//  CLOCK      in   1      clock; all state changes on the rising edge
//  RESET_N    in   1      asynchronous, active-low reset
//  wren       in   1      write request
//  wr_addr    in   AW     write address
//  byte_en    in   NB     byte enables; bit i writes data_in[8i+7:8i]
//  data_in    in   WIDTH  write data
//  rden       in   1      read request
//  rd_addr    in   AW     read address
//  data_out   out  WIDTH  read data
//  rd_valid   out  1      data_out is valid for an accepted read
//  init_done  out  1      high once the init sweep has finished; held until the next reset
// BEHAVIOUR
//  Reset (RESET_N=0): state=S_INIT, sweep_addr=0, init_done=0, rd_valid=0, data_out=0 (latency-1 register).
//    Array contents are not reset directly; the sweep clears them.
//  FSM S_INIT:
//    - each cycle writes INIT_VALUE (all bytes) to mem[sweep_addr], then sweep_addr++
//    - on the cycle that writes sweep_addr==DEPTH-1 -> S_READY
//    - init_done goes high on the next edge (exactly DEPTH cycles after reset release)
//    - wren/rden are ignored; rd_valid=0
//  FSM S_READY: terminal state; leaves only on RESET_N. Reset mid-sweep restarts the sweep at 0.
//  Write (S_READY, wren=1, wr_addr<DEPTH): mem[wr_addr] byte i <= data_in byte i where byte_en[i]=1.
//    Other bytes are unchanged. byte_en=0 is a no-op.
//  Read, READ_LATENCY=0:
//    - data_out = mem[rd_addr] combinationally (pre-edge contents)
//    - rd_valid = rden & init_done
//  Read, READ_LATENCY=1: read accepted when rden & init_done; data_out/rd_valid update on the next edge.
//    - no accepted read: rd_valid=0 and data_out holds its previous value
//  Read-during-write, latency 1, same address:
//    - RDW_NEW: data_out = enabled bytes from data_in, remaining bytes from the old word
//    - RDW_OLD: data_out = the pre-write word
//  Out of range (addr >= DEPTH, non-power-of-2 DEPTH):
//    - write is dropped
//    - read returns 0; rd_valid still asserts as normal
//  Write and read to different addresses in the same cycle are fully independent.
// STRUCTURE
//  Package ram_pkg:
//    - typedef enum {RDW_NEW, RDW_OLD} rdw_mode_e
//    - typedef enum logic {S_INIT, S_READY} ram_state_e
//  Sub-module ram_init_seq: sweep FSM + counter. Outputs sweep_we, sweep_addr, init_done.
//  Top level: muxes sweep vs user write port; read-path register; RDW byte merge.
// TESTING
//  1 Reset release, DEPTH=16, INIT_VALUE=32'hDEAD_BEEF
//    -> init_done rises at cycle 16; reading all 16 addresses returns DEADBEEF; rd_valid=0 before init_done
//  2 Write 32'h1122_3344, byte_en=4'b1111, addr 5; then byte_en=4'b0101 with 32'hAABB_CCDD
//    -> read addr 5 returns 32'h11BB_33DD
//  3 Latency 1: rden at addr 5 in cycle t
//    -> data_out valid and rd_valid=1 at t+1; rd_valid=0 at t+2 if rden=0
//  4 Same-cycle wr/rd addr 7 (old 0, new 32'hCAFE_F00D, all bytes)
//    -> RDW_NEW: CAFEF00D; RDW_OLD: 0
//  5 RESET_N pulsed low at sweep_addr=9
//    -> sweep restarts at 0; init_done waits a full DEPTH cycles; earlier user writes are cleared
//  6 DEPTH=12: write addr 13
//    -> no array change; read addr 13 returns 0 with rd_valid=1

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the dual-port byte-enable RAM: read-during-write mode
// selector and init-sweep state encoding.
package ram_pkg;

   typedef enum {RDW_NEW, RDW_OLD} rdw_mode_e;

   typedef enum logic {S_INIT, S_READY} ram_state_e;

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset init sweep: walks every word address once, then holds READY
// until the next reset.
module ram_init_seq
   import ram_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_addr,
   output logic          init_done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   ram_state_e state;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= S_INIT;
         sweep_addr <= '0;
      end else if (state == S_INIT) begin
         if (sweep_addr == LAST_ADDR) begin
            state <= S_READY;
         end else begin
            sweep_addr <= sweep_addr + AW'(1);
         end
      end
   end

   assign sweep_we  = (state == S_INIT);
   assign init_done = (state == S_READY);

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, selectable read latency,
// defined read-during-write behaviour and a post-reset init sweep.
module ram_dp_be
   import ram_pkg::*;
#(
   parameter int unsigned     WIDTH        = 32,
   parameter int unsigned     DEPTH        = 1024,
   parameter int unsigned     READ_LATENCY = 1,
   parameter rdw_mode_e       RDW_MODE     = RDW_NEW,
   parameter logic [WIDTH-1:0] INIT_VALUE  = '0,
   localparam int unsigned    AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned    NB           = WIDTH / 8
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             wren,
   input  logic [AW-1:0]    wr_addr,
   input  logic [NB-1:0]    byte_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rden,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] data_out,
   output logic             rd_valid,
   output logic             init_done
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             sweep_we;
   logic [AW-1:0]    sweep_addr;
   logic             wr_ok;
   logic             rd_ok;
   logic             rd_in_range;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [NB-1:0]    mem_be;
   logic [WIDTH-1:0] mem_data;
   logic [WIDTH-1:0] rd_word;

   ram_init_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init_seq (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr),
      .init_done  (init_done)
   );

   // User traffic only counts once the sweep is finished; out-of-range writes vanish here.
   assign wr_ok       = init_done & wren & ({1'b0, wr_addr} < DEPTH_W);
   assign rd_ok       = init_done & rden;
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

   always_comb begin
      mem_we   = sweep_we | wr_ok;
      mem_addr = wr_addr;
      mem_be   = byte_en;
      mem_data = data_in;
      if (sweep_we) begin
         mem_addr = sweep_addr;
         mem_be   = '1;
         mem_data = INIT_VALUE;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
         end
      end
   end

   assign rd_word = rd_in_range ? mem[rd_addr] : '0;

   generate
      if (READ_LATENCY == 0) begin : g_async_read
         assign data_out = rd_word;
         assign rd_valid = rd_ok;
      end else begin : g_sync_read
         logic [WIDTH-1:0] rd_merged;

         // New-data mode forwards the enabled write bytes over the stored word.
         always_comb begin
            rd_merged = rd_word;
            if ((RDW_MODE == RDW_NEW) && wr_ok && (wr_addr == rd_addr)) begin
               for (int unsigned i = 0; i < NB; i++) begin
                  if (byte_en[i]) rd_merged[8*i +: 8] = data_in[8*i +: 8];
               end
            end
         end

         always_ff @(posedge CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
               data_out <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_ok;
               if (rd_ok) data_out <= rd_merged;
            end
         end
      end
   endgenerate

endmodule
